// File: rtl/tjrpu_pkg.sv
// Shared Wishbone widths and master state encoding for the tjrpu bus blocks.
package tjrpu_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/tjrpu_wb_master.sv
// Single-transaction Wishbone classic master: command in, one bus cycle with
// ack/err/timeout resolution, response held until consumed.
module tjrpu_wb_master
    import tjrpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0] cmd_sel_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_timeout_o,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic [DAT_W-1:0] wbm_dat_i
);

    // One extra bit so the increment never wraps before the compare.
    localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [16:0]        cnt_inc;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [DAT_W-1:0]   rdat_q, rdat_d;
    logic               err_q, err_d;
    logic               to_q, to_d;

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        to_d    = to_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // err outranks ack, and either outranks a coincident timeout.
                if (wbm_err_i) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (wbm_ack_i) begin
                    rdat_d  = we_q ? '0 : wbm_dat_i;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc[15:0];
                    if (cnt_inc == TO_LIM) begin
                        rdat_d  = '0;
                        err_d   = 1'b0;
                        to_d    = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_dat_o     = rdat_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = to_q;

    assign wbm_cyc_o = (state_q == BUS);
    assign wbm_stb_o = (state_q == BUS);
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: doc/tjrpu_wb_master.md
TJRPU_WB_MASTER -- requirements
Module: tjrpu_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum bus cycles to wait for ack/err before aborting (range 1..65535).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: wb_clk_i  input  1  the single clock, all state is on its rising edge.
REQ-003 SHALL have wb_rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have cmd_valid_i  input  1  command offered.
REQ-005 SHALL have cmd_ready_o  output  1  command accepted this cycle when high together with cmd_valid_i.
REQ-006 SHALL have cmd_we_i  input  1  1=write, 0=read.
REQ-007 SHALL have cmd_adr_i  input  32, cmd_dat_i  input  32, and cmd_sel_i  input  4, giving address, write data and byte lanes.
REQ-008 SHALL have rsp_valid_o  output  1  response available.
REQ-009 SHALL have rsp_ready_i  input  1  response consumed.
REQ-010 SHALL have rsp_dat_o  output  32, holding read data (0 for writes).
REQ-011 SHALL have rsp_err_o  output  1  and rsp_timeout_o  output  1, flagging a slave error or a timeout.
REQ-012 SHALL have wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each, plus wbm_sel_o  output  4, wbm_adr_o  output  32 and wbm_dat_o  output  32, as the Wishbone classic master outputs.
REQ-013 SHALL have wbm_ack_i, wbm_err_i  input  1 each, plus wbm_dat_i  input  32, as the slave responses.

Function
REQ-014 SHALL implement the states IDLE, BUS and RESP.
REQ-015 IDLE: cmd_ready_o=1; on cmd_valid_i, latch we/adr/dat/sel, clear the timeout counter and go to BUS on the next cycle.
REQ-016 BUS: cyc_o=stb_o=1; we/sel/adr/dat SHALL come from registers and stay stable for the whole cycle; cmd_ready_o=0.
REQ-017 BUS, ack_i=1: capture dat_i (reads only; writes give 0), err=0, timeout=0, deassert cyc/stb on the next edge, go to RESP.
REQ-018 BUS, err_i=1 (with or without ack_i): err=1, data=0, go to RESP; err_i SHALL have priority over ack_i.
REQ-019 BUS, no ack/err: count up by 1 per cycle; when the count reaches TIMEOUT_CYCLES, drop cyc/stb, set timeout=1 and data=0, and go to RESP.
REQ-020 An ack/err that arrives on the same cycle the count reaches its limit SHALL win over the timeout.
REQ-021 RESP: rsp_valid_o=1, with rsp_* held stable; on rsp_ready_i go to IDLE; a new command SHALL NOT be accepted in the same cycle.
REQ-022 Minimum latency: accept at edge N, stb high during cycle N+1, zero-wait ack in cycle N+1 -> rsp_valid_o high in cycle N+2.
REQ-023 cyc_o and stb_o SHALL be asserted only in BUS and are never asserted on back-to-back cycles; there SHALL be at least one idle cycle between bus cycles.
REQ-024 ack_i/err_i arriving outside BUS SHALL be ignored.

Reset
REQ-025 Asserting wb_rst_i in any state, including mid-BUS, SHALL force IDLE immediately and asynchronously.
REQ-026 Reset values: cyc/stb/we=0, sel=0, adr=0, dat=0, rsp_valid=0, rsp_dat=0, err=0, timeout=0, counter=0, cmd_ready_o=1 after release.
REQ-027 A transaction aborted by reset SHALL produce no response.

Structure
REQ-028 Shared package tjrpu_pkg SHALL hold the state encoding constants (IDLE=2'd0, BUS=2'd1, RESP=2'd2) and the Wishbone widths (ADR_W=32, DAT_W=32, SEL_W=4).
REQ-029 The design SHALL be a single flat module with no sub-modules; the timeout counter SHALL be 16 bits wide.

Verification
REQ-030 Write test: cmd write adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, ack after 2 wait states -> bus outputs match, stable 3 cycles, rsp_valid with err=0 and timeout=0.
REQ-031 Read test: read adr=0x3000_0000, zero-wait ack with dat_i=0x1234_5678 -> rsp_dat_o=0x1234_5678 two cycles after acceptance.
REQ-032 Error test: err_i and ack_i asserted together -> rsp_err_o=1, rsp_dat_o=0, cyc dropped next cycle.
REQ-033 Timeout test: TIMEOUT_CYCLES=4, no response -> cyc drops after 4 BUS cycles, rsp_timeout_o=1; a late ack then has no effect.
REQ-034 Backpressure and reset test: hold rsp_ready_i=0 for 5 cycles -> rsp stable, cmd_ready_o=0; assert wb_rst_i mid-BUS -> cyc/stb=0 at once, no rsp_valid_o.
